inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

- Boot-time loader that sits directly upstream of the single-cycle MIPS core and its 64x32 instruction memory.
- It accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words.
- It writes each word into the instruction memory write port at consecutive word addresses.
- It holds the core in reset until a complete program has been loaded.

## Interface
Parameters:
- ADDR_W, 6, instruction memory word-address width
- DEPTH, 64, words in instruction memory; must equal 2**ADDR_W

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
- s_valid  in  1  byte valid
- s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid & s_ready at a rising edge
- s_data  in  8  byte payload
- s_last  in  1  marks the final byte of the program; qualified by the transfer
- wr_en  out  1  instruction memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  assembled word
- cpu_rst  out  1  reset to the core; high while not in DONE
- done  out  1  load completed successfully
- error  out  1  load aborted
- words_loaded  out  ADDR_W+1  number of words written in the current or last load

## Operation
- The FSM has four states: IDLE, LOAD, DONE and ERROR.
- Reset values:
  - state = IDLE
  - s_ready = 0, wr_en = 0, wr_addr = 0, wr_data = 0
  - cpu_rst = 1, done = 0, error = 0, words_loaded = 0
  - byte counter = 0
- IDLE:
  - s_ready = 0.
  - start -> LOAD. On entry, clear the byte counter, word index, words_loaded, done and error, and set cpu_rst = 1.
- LOAD:
  - s_ready = 1.
  - Each transfer shifts s_data into the assembly register: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
  - The byte counter runs 0..3 and wraps to 0 after byte 3.
  - On the byte-3 transfer, the next cycle drives wr_en = 1, wr_data = the assembled word and wr_addr = the word index. words_loaded and the word index then increment.
  - s_last on a byte-3 transfer -> DONE after that word is written.
  - Completing word DEPTH-1 -> DONE, regardless of s_last.
  - s_last on a byte 0-2 transfer -> ERROR. The partial word is never written.
  - start is ignored in LOAD.
- DONE:
  - s_ready = 0, done = 1, cpu_rst = 0.
  - start -> LOAD, which reasserts cpu_rst and clears done.
- ERROR:
  - s_ready = 0, error = 1, cpu_rst = 1.
  - start -> LOAD, which clears error.
- Words beyond words_loaded are not cleared; they retain their prior contents.
- words_loaded saturates at DEPTH (its ADDR_W+1 width holds the value 64).

## Timing
- s_ready is a registered function of state. It does not depend on s_valid combinationally.
- wr_en is a registered pulse asserted exactly one cycle after the edge that accepted byte 3.
- Let edge E be the edge that accepts the final byte:
  - after E: wr_en = 1 and state = DONE.
  - after E+1: wr_en = 0, cpu_rst = 0 and done = 1.
  - The last write therefore lands one edge before the core leaves reset.
- s_ready drops to 0 after the edge that accepts the final byte. No extra byte is accepted.
- Back-to-back bytes (s_valid held high) sustain one byte per cycle, i.e. one word every 4 cycles.
- Gaps in s_valid stall assembly. The state and byte counter are held.
- ERROR is entered at the edge that accepts the offending s_last. error and cpu_rst are visible the next cycle.
- rst mid-load returns all outputs to their reset values immediately (asynchronous) and discards any partial word. No write follows.
- start coincident with rst has no effect.

## Structure
- Shared package mips_pkg holds:
  - the loader state enum (IDLE, LOAD, DONE, ERROR)
  - WORD_W = 32
  - IMEM_ADDR_W = 6
- A single sub-module, word_assembler, is natural. It contains the byte counter, the 32-bit shift register and a word_valid pulse output.
- The loader FSM, address counter and cpu_rst/done/error registers live in inst_mem_loader.

## Test plan
- Load a 3-word program: bytes 20 08 00 05, 20 09 00 07, 01 09 50 20, with s_last on the 12th byte.
  - Three wr_en pulses: addr 0 = 0x20080005, addr 1 = 0x20090007, addr 2 = 0x01095020.
  - words_loaded = 3, done = 1, and cpu_rst falls one cycle after the third write.
- Send the same stream with s_valid toggling every other cycle.
  - Identical writes and final state; no byte is lost or duplicated.
- Assert s_last on the 6th byte.
  - Only word 0 is written; error = 1 and cpu_rst stays 1.
  - A following start returns the FSM to LOAD with error = 0.
- Stream 256 bytes without s_last.
  - 64 writes to addresses 0..63, DONE after the 64th write, words_loaded = 64, and s_ready = 0 for byte 257.
- Assert rst after 2 bytes of word 1.
  - No write for word 1; all outputs at reset values.
  - A subsequent start plus a 4-byte load writes addr 0.
- Pulse start in DONE, then send 4 bytes DE AD BE EF with s_last.
  - cpu_rst reasserts the cycle after start, addr 0 = 0xDEADBEEF, done = 1 again.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path: loader states and memory geometry.
package mips_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned IMEM_ADDR_W = 6;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_LOAD  = 2'd1,
      LD_DONE  = 2'd2,
      LD_ERROR = 2'd3
   } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs an accepted byte stream big-endian into 32-bit words.
// word_valid_o pulses for one cycle after the fourth byte of a word is accepted.
module word_assembler
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              accept_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [1:0]        byte_cnt_o,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o
);

   logic [1:0]        cnt_q,   cnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [WORD_W-1:0] word_q,  word_d;
   logic              valid_q, valid_d;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (clear_i) begin
         cnt_d   = 2'd0;
         shift_d = '0;
      end else if (accept_i) begin
         shift_d = {shift_q[WORD_W-BYTE_W-1:0], byte_i};
         cnt_d   = cnt_q + 2'd1;
         // Completed word is latched separately so wr_data stays stable while the next word fills.
         if (cnt_q == 2'd3) begin
            word_d  = shift_d;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 2'd0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign byte_cnt_o   = cnt_q;
   assign word_o       = word_q;
   assign word_valid_o = valid_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core in
// reset until a complete program has been written.
module inst_mem_loader
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [BYTE_W-1:0] s_data,
   input  logic              s_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   loader_state_e     state_q, state_d;
   logic              s_ready_q, s_ready_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              xfer;
   logic              byte3;
   logic              go;
   logic [1:0]        byte_cnt;

   assign xfer  = s_valid & s_ready_q;
   assign byte3 = xfer & (byte_cnt == 2'd3);
   assign go    = start & (state_q != LD_LOAD);

   word_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (go),
      .accept_i     (xfer),
      .byte_i       (s_data),
      .byte_cnt_o   (byte_cnt),
      .word_o       (wr_data),
      .word_valid_o (wr_en)
   );

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      wr_addr_d  = wr_addr_q;
      words_d    = words_q;
      cpu_rst_d  = cpu_rst_q;
      done_d     = done_q;
      error_d    = error_q;

      unique case (state_q)
         LD_IDLE: begin
            cpu_rst_d = 1'b1;
         end
         LD_LOAD: begin
            if (byte3) begin
               wr_addr_d  = word_idx_q;
               word_idx_d = word_idx_q + ADDR_W'(1);
               if (words_q != (ADDR_W+1)'(DEPTH))
                  words_d = words_q + (ADDR_W+1)'(1);
               if (s_last || (word_idx_q == ADDR_W'(DEPTH - 1)))
                  state_d = LD_DONE;
            end else if (xfer && s_last) begin
               state_d = LD_ERROR;
               error_d = 1'b1;
            end
         end
         LD_DONE: begin
            // Released one edge after entry so the final write lands first.
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
         end
         LD_ERROR: begin
            error_d   = 1'b1;
            cpu_rst_d = 1'b1;
         end
         default: state_d = LD_IDLE;
      endcase

      if (go) begin
         state_d    = LD_LOAD;
         word_idx_d = '0;
         words_d    = '0;
         done_d     = 1'b0;
         error_d    = 1'b0;
         cpu_rst_d  = 1'b1;
      end

      s_ready_d = (state_d == LD_LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LD_IDLE;
         s_ready_q  <= 1'b0;
         word_idx_q <= '0;
         wr_addr_q  <= '0;
         words_q    <= '0;
         cpu_rst_q  <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_ready_q  <= s_ready_d;
         word_idx_q <= word_idx_d;
         wr_addr_q  <= wr_addr_d;
         words_q    <= words_d;
         cpu_rst_q  <= cpu_rst_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign s_ready      = s_ready_q;
   assign wr_addr      = wr_addr_q;
   assign cpu_rst      = cpu_rst_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: program loads, stalls, aborts, full-depth load and reset.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cpu_rst;
   logic        done;
   logic        error;
   logic [6:0]  words_loaded;

   int total = 0;
   int bad   = 0;

   logic [5:0]  log_addr [512];
   logic [31:0] log_data [512];
   int          wcount = 0;

   inst_mem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_rst      (cpu_rst),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Write log sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1 && wcount < 512) begin
         log_addr[wcount] <= wr_addr;
         log_data[wcount] <= wr_data;
         wcount           <= wcount + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // Offer one byte until accepted; optional idle cycle afterwards.
   task automatic send_byte(input logic [7:0] b, input logic last, input logic gap);
      int  n;
      logic ok;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      s_last  = last;
      for (n = 0; n < 20 && !ok; n++) begin
         if (s_ready === 1'b1) ok = 1'b1;
         cyc();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) chk("send_timeout", 32'(ok), 32'd1);
      if (gap) cyc();
   endtask

   task automatic send_word(input logic [31:0] w, input logic last, input logic gap);
      send_byte(w[31:24], 1'b0, gap);
      send_byte(w[23:16], 1'b0, gap);
      send_byte(w[15:8],  1'b0, gap);
      send_byte(w[7:0],   last, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_wr_en"},   32'(wr_en),   32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, wr_data,      32'd0);
      chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
      chk({tag, "_done"},    32'(done),    32'd0);
      chk({tag, "_error"},   32'(error),   32'd0);
      chk({tag, "_words"},   32'(words_loaded), 32'd0);
   endtask

   initial begin
      int base;
      logic [31:0] w;
      logic [31:0] prog [3];
      prog[0] = 32'h20080005;
      prog[1] = 32'h20090007;
      prog[2] = 32'h01095020;

      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      cyc(); cyc();
      chk_reset_outputs("rst");
      rst = 1'b0;
      cyc();
      chk("idle_s_ready", 32'(s_ready), 32'd0);

      // 3-word program, back-to-back bytes.
      base = wcount;
      pulse_start();
      chk("t1_s_ready", 32'(s_ready), 32'd1);
      send_word(prog[0], 1'b0, 1'b0);
      send_word(prog[1], 1'b0, 1'b0);
      send_word(prog[2], 1'b1, 1'b0);
      chk("t1_E_wr_en",   32'(wr_en),   32'd1);
      chk("t1_E_s_ready", 32'(s_ready), 32'd0);
      chk("t1_E_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t1_E_done",    32'(done),    32'd0);
      cyc();
      chk("t1_E1_wr_en",   32'(wr_en),   32'd0);
      chk("t1_E1_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("t1_E1_done",    32'(done),    32'd1);
      chk("t1_words",      32'(words_loaded), 32'd3);
      chk("t1_nwr",        32'(wcount - base), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_addr", 32'(log_addr[base+i]), 32'(i));
         chk("t1_data", log_data[base+i], prog[i]);
      end

      // Same program with s_valid toggling.
      base = wcount;
      pulse_start();
      chk("t2_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t2_done",    32'(done),    32'd0);
      send_word(prog[0], 1'b0, 1'b1);
      cyc();
      send_word(prog[1], 1'b0, 1'b1);
      cyc();
      send_word(prog[2], 1'b1, 1'b1);
      cyc();
      chk("t2_done_f",  32'(done),    32'd1);
      chk("t2_cpu_rst_f", 32'(cpu_rst), 32'd0);
      chk("t2_words",   32'(words_loaded), 32'd3);
      chk("t2_nwr",     32'(wcount - base), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("t2_addr", 32'(log_addr[base+i]), 32'(i));
         chk("t2_data", log_data[base+i], prog[i]);
      end

      // s_last on byte 6 aborts.
      base = wcount;
      pulse_start();
      send_word(prog[0], 1'b0, 1'b0);
      send_byte(8'h20, 1'b0, 1'b0);
      send_byte(8'h09, 1'b1, 1'b0);
      chk("t3_s_ready", 32'(s_ready), 32'd0);
      cyc(); cyc();
      chk("t3_error",   32'(error),   32'd1);
      chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t3_done",    32'(done),    32'd0);
      chk("t3_nwr",     32'(wcount - base), 32'd1);
      chk("t3_addr",    32'(log_addr[base]), 32'd0);
      chk("t3_data",    log_data[base], prog[0]);
      pulse_start();
      chk("t3_restart_error", 32'(error),   32'd0);
      chk("t3_restart_ready", 32'(s_ready), 32'd1);

      // 256 bytes without s_last fill the memory.
      base = wcount;
      for (int i = 0; i < 256; i++) send_byte(8'(i * 7 + 3), 1'b0, 1'b0);
      chk("t4_E_s_ready", 32'(s_ready), 32'd0);
      chk("t4_E_wr_en",   32'(wr_en),   32'd1);
      s_valid = 1'b1; s_data = 8'hAA;
      cyc();
      chk("t4_done",  32'(done),    32'd1);
      chk("t4_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("t4_byte257_ready", 32'(s_ready), 32'd0);
      cyc(); cyc();
      s_valid = 1'b0;
      chk("t4_words", 32'(words_loaded), 32'd64);
      chk("t4_nwr",   32'(wcount - base), 32'd64);
      for (int k = 0; k < 64; k++) begin
         for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((4*k + j) * 7 + 3);
         chk("t4_addr", 32'(log_addr[base+k]), 32'(k));
         chk("t4_data", log_data[base+k], w);
      end

      // Reset after 2 bytes of word 1.
      base = wcount;
      pulse_start();
      send_word(32'hCAFEF00D, 1'b0, 1'b0);
      send_byte(8'h12, 1'b0, 1'b0);
      send_byte(8'h34, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("t5");
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      chk("t5_nwr", 32'(wcount - base), 32'd1);
      chk("t5_idle_ready", 32'(s_ready), 32'd0);
      base = wcount;
      pulse_start();
      send_word(32'h11223344, 1'b1, 1'b0);
      cyc();
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_nwr2", 32'(wcount - base), 32'd1);
      chk("t5_addr", 32'(log_addr[base]), 32'd0);
      chk("t5_data", log_data[base], 32'h11223344);

      // Restart from DONE with DEADBEEF.
      base = wcount;
      pulse_start();
      chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t6_done0",   32'(done),    32'd0);
      send_word(32'hDEADBEEF, 1'b1, 1'b0);
      cyc();
      chk("t6_done",    32'(done),    32'd1);
      chk("t6_cpu_rst_f", 32'(cpu_rst), 32'd0);
      chk("t6_words",   32'(words_loaded), 32'd1);
      chk("t6_nwr",     32'(wcount - base), 32'd1);
      chk("t6_addr",    32'(log_addr[base]), 32'd0);
      chk("t6_data",    log_data[base], 32'hDEADBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
